// File: rtl/rv32_ifetch_queue_if.sv
// Fetch-unit bundle: memory request/response, pipeline redirect and decode-side queue head.
// The fetch unit is the master; the memory/pipeline environment is the slave.
interface rv32_ifetch_queue_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/rv32_ifetch_queue.sv
// RV32 instruction fetch unit: credit-limited sequential fetch into a {pc, word} queue,
// with redirect flushing that drops responses still in flight from the old path.
module rv32_ifetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    rv32_ifetch_queue_if.master bus
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] PC0 = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {FETCH, FLUSH} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_word [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_after_pop;
    logic [CW-1:0] outst_q, outst_d, drop_q, drop_d;
    logic          instr_valid_q, instr_valid_d;
    logic [31:0]   instr_q, instr_d, instr_pc_q, instr_pc_d;

    logic          req_valid, req_acc, rsp_hit, push, pop;
    logic [31:0]   rsp_pc;
    logic [CW:0]   credits_used;

    // Requests are sequential, so the oldest outstanding PC is derived from the current PC.
    assign credits_used = {1'b0, outst_q} + {1'b0, cnt_q};
    assign req_valid    = !rst && (state_q == FETCH) && !bus.redirect_valid
                          && (credits_used < (CW+1)'(DEPTH));
    assign req_acc      = req_valid && bus.mem_req_ready;
    assign rsp_hit      = bus.mem_rsp_valid && (outst_q != '0);
    assign rsp_pc       = pc_q - 32'({outst_q, 2'b00});
    assign push         = (state_q == FETCH) && rsp_hit && !bus.redirect_valid;
    assign pop          = instr_valid_q && bus.instr_ready && !bus.redirect_valid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rd_d          = rd_q;
        wr_d          = wr_q;
        outst_d       = outst_q;
        drop_d        = drop_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        cnt_after_pop = cnt_q - CW'(pop);
        cnt_d         = cnt_after_pop + CW'(push);

        if (req_acc) begin
            pc_d    = pc_q + 32'd4;
            outst_d = outst_q + CW'(1);
        end
        if (rsp_hit) outst_d = outst_d - CW'(1);
        if (push)    wr_d = wr_q + PW'(1);
        if (pop)     rd_d = rd_q + PW'(1);

        // Head registers follow the next head: bypass the push when the queue drains to it.
        if (cnt_after_pop == '0) begin
            if (push) begin
                instr_d    = bus.mem_rsp_data;
                instr_pc_d = rsp_pc;
            end
        end else begin
            instr_d    = fifo_word[rd_d];
            instr_pc_d = fifo_pc[rd_d];
        end

        unique case (state_q)
            FETCH: begin
                if (bus.redirect_valid) begin
                    drop_d  = outst_d;
                    state_d = (outst_d != '0) ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if (rsp_hit) drop_d = drop_q - CW'(1);
                if (drop_d == '0) state_d = FETCH;
            end
        endcase

        if (bus.redirect_valid) begin
            pc_d  = bus.redirect_pc & 32'hFFFF_FFFC;
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
        instr_valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_q          <= PC0;
            rd_q          <= '0;
            wr_q          <= '0;
            cnt_q         <= '0;
            outst_q       <= '0;
            drop_q        <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rd_q          <= rd_d;
            wr_q          <= wr_d;
            cnt_q         <= cnt_d;
            outst_q       <= outst_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    // Queue storage needs no reset; occupancy is tracked by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_q]   <= rsp_pc;
            fifo_word[wr_q] <= bus.mem_rsp_data;
        end
    end

    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_addr  = pc_q;
    assign bus.instr_valid   = instr_valid_q;
    assign bus.instr         = instr_q;
    assign bus.instr_pc      = instr_pc_q;
endmodule

// File: tb/tb_rv32_ifetch_queue.sv
// Directed bench for rv32_ifetch_queue: one-cycle memory model, redirect/flush, back-pressure,
// PC wrap and asynchronous reset scenarios.
module tb_rv32_ifetch_queue;
    logic clk;
    logic rst;

    rv32_ifetch_queue_if bus();
    rv32_ifetch_queue_if bus1();

    rv32_ifetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    rv32_ifetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int          checks;
    int          errors;
    bit          mem_auto;
    logic [31:0] pend[$];
    logic [31:0] acc_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_word[$];
    logic [31:0] acc1[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    // Drive this cycle's memory response, then record handshakes seen before the rising edge.
    task automatic prep();
        if (mem_auto && pend.size() != 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(pend[0]);
        end else begin
            bus.mem_rsp_valid = 1'b0;
            bus.mem_rsp_data  = '0;
        end
        #1;
        if (!rst) begin
            assert (!(bus.mem_rsp_valid && pend.size() == 0))
                else $error("protocol violation: response with no outstanding fetch");
            if (bus.mem_rsp_valid) void'(pend.pop_front());
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                pend.push_back(bus.mem_req_addr);
                acc_log.push_back(bus.mem_req_addr);
            end
            if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
                pop_pc.push_back(bus.instr_pc);
                pop_word.push_back(bus.instr);
            end
            if (bus1.mem_req_valid && bus1.mem_req_ready) acc1.push_back(bus1.mem_req_addr);
        end
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic cycle();
        prep();
        adv();
    endtask

    task automatic clear_logs();
        pend.delete(); acc_log.delete(); pop_pc.delete(); pop_word.delete(); acc1.delete();
    endtask

    task automatic do_reset();
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.mem_req_ready = 1'b0;
        bus.instr_ready = 1'b0; bus.mem_rsp_valid = 1'b0; mem_auto = 1'b0;
        rst = 1'b1;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_logs();
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
        checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", bus.instr_pc); end
        rst = 1'b0;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid: got %b expected 1", bus.mem_req_valid); end
        checks++; if (bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL release_req_addr: got %h expected 00000000", bus.mem_req_addr); end
        adv();
    endtask

    task automatic test_wrap();
        logic [31:0] exp [3];
        exp[0] = 32'hFFFF_FFF8; exp[1] = 32'hFFFF_FFFC; exp[2] = 32'h0000_0000;
        repeat (3) cycle();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= acc1.size() || acc1[i] !== exp[i]) begin
                errors++;
                $display("FAIL wrap_addr[%0d]: got %h expected %h", i, (i < acc1.size()) ? acc1[i] : 32'hx, exp[i]);
            end
        end
    endtask

    task automatic test_stream();
        do_reset();
        bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1; mem_auto = 1'b1;
        repeat (10) cycle();
        checks++; if (acc_log.size() != 10) begin errors++; $display("FAIL stream_req_count: got %0d expected 10", acc_log.size()); end
        checks++; if (pop_pc.size() != 8) begin errors++; $display("FAIL stream_pop_count: got %0d expected 8", pop_pc.size()); end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= acc_log.size() || acc_log[i] !== 32'(4*i)) begin
                errors++;
                $display("FAIL stream_addr[%0d]: got %h expected %h", i, (i < acc_log.size()) ? acc_log[i] : 32'hx, 32'(4*i));
            end
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= pop_pc.size() || pop_pc[i] !== 32'(4*i) || pop_word[i] !== mem_word(32'(4*i))) begin
                errors++;
                $display("FAIL stream_pop[%0d]: got pc %h word %h expected pc %h word %h", i,
                         (i < pop_pc.size()) ? pop_pc[i] : 32'hx, (i < pop_word.size()) ? pop_word[i] : 32'hx,
                         32'(4*i), mem_word(32'(4*i)));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b0; mem_auto = 1'b1;
        repeat (8) cycle();
        checks++; if (acc_log.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", acc_log.size()); end
        prep();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_no_credit: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_instr_valid: got %b expected 1", bus.instr_valid); end
        checks++; if (bus.instr_pc !== 32'h0 || bus.instr !== mem_word(32'h0)) begin errors++; $display("FAIL bp_head_hold: got pc %h word %h expected pc 00000000 word %h", bus.instr_pc, bus.instr, mem_word(32'h0)); end
        adv();
        bus.instr_ready = 1'b1;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_valid: got %b expected 0", bus.mem_req_valid); end
        adv();
        bus.instr_ready = 1'b0;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h10) begin errors++; $display("FAIL bp_credit_back: got valid %b addr %h expected valid 1 addr 00000010", bus.mem_req_valid, bus.mem_req_addr); end
        checks++; if (bus.instr_pc !== 32'h4) begin errors++; $display("FAIL bp_next_head: got %h expected 00000004", bus.instr_pc); end
        adv();
    endtask

    task automatic test_redirect_flush();
        do_reset();
        bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1; mem_auto = 1'b0;
        repeat (3) cycle();
        checks++; if (acc_log.size() != 3) begin errors++; $display("FAIL flush_outstanding: got %0d expected 3", acc_log.size()); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_redirect_cycle_valid: got %b expected 0", bus.mem_req_valid); end
        adv();
        bus.redirect_valid = 1'b0;
        pop_pc.delete(); pop_word.delete();
        prep();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_wait_valid: got %b expected 0", bus.mem_req_valid); end
        adv();
        mem_auto = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prep();
            checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]_valid: got %b expected 0", k, bus.mem_req_valid); end
            adv();
        end
        prep();
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h100) begin errors++; $display("FAIL flush_resume: got valid %b addr %h expected valid 1 addr 00000100", bus.mem_req_valid, bus.mem_req_addr); end
        adv();
        repeat (4) cycle();
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== 32'h100 || pop_word[0] !== mem_word(32'h100)) begin
            errors++;
            $display("FAIL flush_first_pop: got pc %h word %h expected pc 00000100 word %h",
                     (pop_pc.size() != 0) ? pop_pc[0] : 32'hx, (pop_word.size() != 0) ? pop_word[0] : 32'hx, mem_word(32'h100));
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1; mem_auto = 1'b1;
        repeat (4) cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0203;
        prep();
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL collide_pre_valid: got %b expected 1", bus.instr_valid); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL collide_req_valid: got %b expected 0", bus.mem_req_valid); end
        adv();
        bus.redirect_valid = 1'b0;
        pop_pc.delete(); pop_word.delete();
        prep();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL collide_fifo_empty: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h200) begin errors++; $display("FAIL collide_resume: got valid %b addr %h expected valid 1 addr 00000200", bus.mem_req_valid, bus.mem_req_addr); end
        adv();
        repeat (4) cycle();
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== 32'h200 || pop_word[0] !== mem_word(32'h200)) begin
            errors++;
            $display("FAIL collide_first_pop: got pc %h word %h expected pc 00000200 word %h",
                     (pop_pc.size() != 0) ? pop_pc[0] : 32'hx, (pop_word.size() != 0) ? pop_word[0] : 32'hx, mem_word(32'h200));
        end
    endtask

    task automatic test_redirect_in_flush();
        do_reset();
        bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b1; mem_auto = 1'b0;
        repeat (2) cycle();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0040;
        cycle();
        bus.redirect_pc = 32'h0000_0080;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reflush_valid: got %b expected 0", bus.mem_req_valid); end
        adv();
        bus.redirect_valid = 1'b0; mem_auto = 1'b1;
        for (int k = 0; k < 2; k++) begin
            prep();
            checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL reflush_drop[%0d]_valid: got %b expected 0", k, bus.mem_req_valid); end
            adv();
        end
        prep();
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h80) begin errors++; $display("FAIL reflush_resume: got valid %b addr %h expected valid 1 addr 00000080", bus.mem_req_valid, bus.mem_req_addr); end
        adv();
    endtask

    task automatic test_reset_midway();
        do_reset();
        bus.mem_req_ready = 1'b1; bus.instr_ready = 1'b0; mem_auto = 1'b0;
        repeat (2) cycle();
        mem_auto = 1'b1;
        repeat (2) cycle();
        mem_auto = 1'b0;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_credit_full: got %b expected 0", bus.mem_req_valid); end
        checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", bus.instr_valid); end
        adv();
        #2 rst = 1'b1;
        #1;
        clear_logs();
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_instr_valid: got %b expected 0", bus.instr_valid); end
        checks++; if (bus.mem_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_req_valid: got %b expected 0", bus.mem_req_valid); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.instr_ready = 1'b1; mem_auto = 1'b1;
        prep();
        checks++; if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== 32'h0) begin errors++; $display("FAIL midrst_restart: got valid %b addr %h expected valid 1 addr 00000000", bus.mem_req_valid, bus.mem_req_addr); end
        adv();
        repeat (4) cycle();
        checks++;
        if (pop_pc.size() == 0 || pop_pc[0] !== 32'h0 || pop_word[0] !== mem_word(32'h0)) begin
            errors++;
            $display("FAIL midrst_first_pop: got pc %h word %h expected pc 00000000 word %h",
                     (pop_pc.size() != 0) ? pop_pc[0] : 32'hx, (pop_word.size() != 0) ? pop_word[0] : 32'hx, mem_word(32'h0));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        mem_auto = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.instr_ready = 1'b0;
        bus1.mem_req_ready = 1'b1; bus1.mem_rsp_valid = 1'b0; bus1.mem_rsp_data = '0;
        bus1.redirect_valid = 1'b0; bus1.redirect_pc = '0; bus1.instr_ready = 1'b0;

        test_reset();
        test_wrap();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_collide();
        test_redirect_in_flush();
        test_reset_midway();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
